onehot_encoder_reg: RTL and testbench
=====================================

Name: onehot_encoder_reg

Overview:
- Registered one-hot to binary encoder for the register-file datapath; the inverse of the 5-to-32 one-hot write-select decoder.
- Converts a 32-bit one-hot select vector into a 5-bit register index.
- Uses a valid/ready handshake and a one-entry output stage.
- Flags zero-hot and multi-hot inputs and keeps a saturating error count for debug readback.

Parameters:
- N_SEL, 32, width of one-hot input; must be a power of two.
- IDX_W, 5, output index width = log2(N_SEL).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  din is presented.
- in_ready  output  1  block can accept din this cycle.
- din  input  N_SEL  one-hot select vector.
- out_valid  output  1  dout and the error flags are valid.
- out_ready  input  1  consumer accepts dout.
- dout  output  IDX_W  encoded index.
- zero_err  output  1  accepted din was all zeros.
- multi_err  output  1  accepted din had more than one bit set.
- err_cnt  output  CNT_W  saturating count of erroneous accepted inputs.
- err_clr  input  1  synchronous clear of err_cnt.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n); all state clears immediately on rst_n low.
- Reset values: out_valid=0, dout=0, zero_err=0, multi_err=0, err_cnt=0. in_ready=1 after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Latency: exactly 1 cycle. Data accepted at edge k is visible on dout/out_valid after edge k.
- Full throughput: with out_ready held high, one result per cycle.
- Output stage FSM, two states:
  - EMPTY (out_valid=0): accept -> FULL.
  - FULL (out_valid=1): transfer without accept -> EMPTY; transfer with accept -> FULL with new data; no transfer -> hold.
- Stall rule: while FULL and out_ready=0, dout, zero_err and multi_err hold stable and in_ready=0.
- Encoding rules:
  - Exactly one bit i set: dout=i, both flags 0.
  - din==0: dout=0, zero_err=1, multi_err=0.
  - Multi-hot: dout = index of the lowest set bit, multi_err=1, zero_err=0.
- Flags are registered with dout and valid only while out_valid=1. They are not sticky.
- err_cnt:
  - Increments by 1 on each accepted erroneous input, counted at accept, not at transfer.
  - Saturates at 2^CNT_W-1; no wrap.
  - err_clr alone -> 0 next cycle.
  - err_clr and erroneous accept in the same cycle -> err_cnt=1.
- in_valid while in_ready=0: no effect; the producer must hold din.
- Reset mid-operation: a pending output is discarded; no partial transfer.
- Any rst_n assertion, even sub-cycle, clears state; deassertion is synchronised externally.

Decomposition:
- Shared package regfile_pkg:
  - N_SEL=32, IDX_W=5.
  - Function popcount_ge2 (multi-hot detect).
  - Function lsb_index (lowest-set-bit encode).
  - Both reused by the decoder bench.
- One sub-module is natural: onehot_encoder_comb (pure combinational index, zero and multi detect). onehot_encoder_reg wraps it with the output register, FSM and counter.

Test Plan:
- Reset: rst_n=0 then release -> out_valid=0, dout=0, err_cnt=0, in_ready=1.
- Sweep: din=32'h1<<i for i=0..31 back-to-back, out_ready=1 -> dout=i one cycle later, no flags, no bubbles, err_cnt=0.
- Backpressure: din=32'h0000_0400 accepted, out_ready=0 for 3 cycles -> dout=10 held, in_ready=0; out_ready=1 with next din=32'h8000_0000 -> dout=31 following cycle.
- Errors:
  - din=32'h0 -> zero_err=1, dout=0.
  - din=32'h0000_0018 -> multi_err=1, dout=3.
  - err_cnt=2 after both.
- Counter boundaries:
  - 300 consecutive errors -> err_cnt=255 (saturated).
  - err_clr with simultaneous error accept -> err_cnt=1.
  - err_clr alone -> 0.
- Async reset mid-stream: assert rst_n low between edges while out_valid=1, dout=7 -> out_valid=0, dout=0 immediately, no transfer observed.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register-file select datapath.
// Holds the select-vector geometry, the encoder output-stage state type
// and helper functions for multi-hot detection and lowest-set-bit
// encoding, which are shared by the encoder RTL and the decoder bench.
package regfile_pkg;

   localparam int N_SEL = 32;   // width of the one-hot select vector (power of two)
   localparam int IDX_W = 5;    // log2(N_SEL)

   // One-entry output stage occupancy.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_state_t;

   // True when two or more bits are set: clearing the lowest set bit
   // leaves something behind only if another bit was set.
   function automatic logic popcount_ge2(input logic [N_SEL-1:0] v);
      return |(v & (v - N_SEL'(1)));
   endfunction

   // Index of the lowest set bit; 0 when no bit is set. Scanning from the
   // top down lets the lowest hit overwrite all higher ones.
   function automatic logic [IDX_W-1:0] lsb_index(input logic [N_SEL-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = N_SEL - 1; i >= 0; i--) begin
         if (v[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/onehot_encoder_comb.sv
// onehot_encoder_comb: purely combinational one-hot to binary encoder.
// Ports:
//   sel   in  N_SEL  select vector
//   idx   out IDX_W  index of the lowest set bit (0 when sel is zero)
//   zero  out 1      sel has no bit set
//   multi out 1      sel has more than one bit set
module onehot_encoder_comb
   import regfile_pkg::*;
(
   input  logic [N_SEL-1:0] sel,
   output logic [IDX_W-1:0] idx,
   output logic             zero,
   output logic             multi
);

   always_comb begin
      idx   = lsb_index(sel);
      zero  = ~|sel;
      multi = popcount_ge2(sel);
   end

endmodule

// File: rtl/onehot_encoder_reg.sv
// onehot_encoder_reg: registered one-hot to binary encoder with a
// valid/ready handshake, a one-entry output stage and a saturating
// error counter for debug readback.
// Ports:
//   clk       in  1      system clock, rising edge
//   rst_n     in  1      asynchronous active-low reset
//   in_valid  in  1      din is presented
//   in_ready  out 1      din can be accepted this cycle
//   din       in  N_SEL  one-hot select vector
//   out_valid out 1      dout and error flags are valid
//   out_ready in  1      consumer accepts dout
//   dout      out IDX_W  encoded index (lowest set bit)
//   zero_err  out 1      accepted din was all zeros
//   multi_err out 1      accepted din had more than one bit set
//   err_cnt   out CNT_W  saturating count of erroneous accepted inputs
//   err_clr   in  1      synchronous clear of err_cnt
module onehot_encoder_reg
   import regfile_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_SEL-1:0] din,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] dout,
   output logic             zero_err,
   output logic             multi_err,
   output logic [CNT_W-1:0] err_cnt,
   input  logic             err_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   stage_state_t     state_reg, state_next;
   logic [IDX_W-1:0] dout_reg;
   logic             zero_reg;
   logic             multi_reg;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   logic [IDX_W-1:0] enc_idx;
   logic             enc_zero;
   logic             enc_multi;
   logic             accept;
   logic             transfer;
   logic             err_accept;

   onehot_encoder_comb u_comb (
      .sel   (din),
      .idx   (enc_idx),
      .zero  (enc_zero),
      .multi (enc_multi)
   );

   assign out_valid  = (state_reg == ST_FULL);
   assign in_ready   = !out_valid || out_ready;
   assign accept     = in_valid && in_ready;
   assign transfer   = out_valid && out_ready;
   assign err_accept = accept && (enc_zero || enc_multi);

   // Output stage occupancy: a new accept always lands in the stage,
   // since in_ready already guarantees the old entry is leaving.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_EMPTY: if (accept) state_next = ST_FULL;
         ST_FULL: begin
            if (accept)        state_next = ST_FULL;
            else if (transfer) state_next = ST_EMPTY;
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   // Clear takes priority over the old count, but an error accepted in the
   // same cycle is still counted on top of the cleared value.
   always_comb begin
      cnt_next = cnt_reg;
      if (err_clr)
         cnt_next = err_accept ? CNT_W'(1) : '0;
      else if (err_accept && cnt_reg != CNT_MAX)
         cnt_next = cnt_reg + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_EMPTY;
         dout_reg  <= '0;
         zero_reg  <= 1'b0;
         multi_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            dout_reg  <= enc_idx;
            zero_reg  <= enc_zero;
            multi_reg <= enc_multi;
         end
      end
   end

   assign dout      = dout_reg;
   assign zero_err  = zero_reg;
   assign multi_err = multi_reg;
   assign err_cnt   = cnt_reg;

endmodule

// File: tb/tb_onehot_encoder_reg.sv
// tb_onehot_encoder_reg: directed bench for onehot_encoder_reg with a
// scoreboard queue of expected outputs and an occupancy/counter model.
module tb_onehot_encoder_reg;

   localparam int N   = 32;
   localparam int IW  = 5;
   localparam int CW  = 8;

   typedef struct packed {
      logic [IW-1:0] idx;
      logic          zero;
      logic          multi;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  din;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] dout;
   logic          zero_err;
   logic          multi_err;
   logic [CW-1:0] err_cnt;
   logic          err_clr;

   int vectors    = 0;
   int miscompares = 0;

   exp_t          sb[$];
   logic          model_full = 1'b0;
   int            model_cnt  = 0;

   always #5 clk = ~clk;

   onehot_encoder_reg #(.CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din       (din),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .zero_err  (zero_err),
      .multi_err (multi_err),
      .err_cnt   (err_cnt),
      .err_clr   (err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Reference encoding written independently of the RTL helpers.
   function automatic exp_t ref_enc(input logic [N-1:0] v);
      exp_t e;
      int   ones;
      e.idx = '0;
      ones  = $countones(v);
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            e.idx = IW'(i);
            break;
         end
      end
      e.zero  = (ones == 0);
      e.multi = (ones > 1);
      return e;
   endfunction

   // Called just after a negedge with inputs driven: checks outputs against
   // the model, then advances one clock and updates the model.
   task automatic cycle();
      logic acc, xfer;
      exp_t e;
      #1;
      chk("out_valid", 32'(out_valid), 32'(model_full));
      chk("in_ready", 32'(in_ready), 32'(!model_full || out_ready));
      chk("err_cnt", 32'(err_cnt), 32'(model_cnt));
      if (model_full) begin
         chk("dout", 32'(dout), 32'(sb[0].idx));
         chk("zero_err", 32'(zero_err), 32'(sb[0].zero));
         chk("multi_err", 32'(multi_err), 32'(sb[0].multi));
      end
      acc  = in_valid && (!model_full || out_ready);
      xfer = model_full && out_ready;
      e    = ref_enc(din);
      @(posedge clk);
      if (xfer) begin
         $display("xfer dout=%0d zero=%0b multi=%0b err_cnt=%0d", dout, zero_err, multi_err, err_cnt);
         void'(sb.pop_front());
      end
      if (acc) sb.push_back(e);
      model_full = (sb.size() != 0);
      if (err_clr)
         model_cnt = (acc && (e.zero || e.multi)) ? 1 : 0;
      else if (acc && (e.zero || e.multi) && model_cnt < 255)
         model_cnt++;
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [N-1:0] d, input logic r, input logic c);
      in_valid  = v;
      din       = d;
      out_ready = r;
      err_clr   = c;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      chk("rst out_valid", 32'(out_valid), 32'h0);
      chk("rst dout", 32'(dout), 32'h0);
      chk("rst err_cnt", 32'(err_cnt), 32'h0);
      chk("rst in_ready", 32'(in_ready), 32'h1);
      chk("rst flags", {30'h0, zero_err, multi_err}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back sweep of every single-bit select.
      for (int i = 0; i < N; i++) begin
         drive(1'b1, N'(1) << i, 1'b1, 1'b0);
         cycle();
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      cycle();
      cycle();
      chk("sweep err_cnt", 32'(err_cnt), 32'h0);

      // Backpressure: index 10 must hold while the next input waits.
      drive(1'b1, 32'h0000_0400, 1'b1, 1'b0);
      cycle();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'h8000_0000, 1'b0, 1'b0);
         cycle();
         chk("stall dout", 32'(dout), 32'd10);
         chk("stall in_ready", 32'(in_ready), 32'h0);
      end
      drive(1'b1, 32'h8000_0000, 1'b1, 1'b0);
      cycle();
      drive(1'b0, '0, 1'b1, 1'b0);
      #1;
      chk("bp dout", 32'(dout), 32'd31);
      cycle();
      cycle();

      // Zero-hot and multi-hot inputs.
      drive(1'b1, 32'h0, 1'b1, 1'b0);
      cycle();
      drive(1'b1, 32'h0000_0018, 1'b1, 1'b0);
      cycle();
      drive(1'b0, '0, 1'b1, 1'b0);
      cycle();
      cycle();
      chk("err_cnt two", 32'(err_cnt), 32'd2);

      // Saturation, then clear with and without a simultaneous error.
      for (int k = 0; k < 300; k++) begin
         drive(1'b1, 32'h0, 1'b1, 1'b0);
         cycle();
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      cycle();
      chk("err_cnt sat", 32'(err_cnt), 32'd255);
      drive(1'b1, 32'h0000_0003, 1'b1, 1'b1);
      cycle();
      drive(1'b0, '0, 1'b1, 1'b0);
      cycle();
      chk("err_cnt clr+err", 32'(err_cnt), 32'd1);
      drive(1'b0, '0, 1'b1, 1'b1);
      cycle();
      drive(1'b0, '0, 1'b1, 1'b0);
      cycle();
      chk("err_cnt clr", 32'(err_cnt), 32'd0);

      // Asynchronous reset between edges with a pending entry.
      drive(1'b1, 32'h0000_0080, 1'b0, 1'b0);
      cycle();
      drive(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("pre-rst dout", 32'(dout), 32'd7);
      chk("pre-rst out_valid", 32'(out_valid), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async out_valid", 32'(out_valid), 32'h0);
      chk("async dout", 32'(dout), 32'h0);
      sb.delete();
      model_full = 1'b0;
      model_cnt  = 0;
      out_ready  = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
